// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe auto player: cell encodings,
// winning-line table, cell groups, FSM states and small board helpers.
// Optional feature macro: TTT_AUTO_LFSR_EN (random tie-break, see ttt_move_picker).
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Every three-in-a-row line as cell indices (a=0 .. i=8).
  localparam int LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  localparam int CENTRE      = 4;
  localparam int CORNERS [4] = '{0, 2, 6, 8};
  localparam int EDGES   [4] = '{1, 3, 5, 7};

  // Same cell groups as bit masks, bit n = cell n.
  localparam logic [8:0] CORNER_MASK = 9'b1_0100_0101;
  localparam logic [8:0] EDGE_MASK   = 9'b0_1010_1010;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    THINK    = 3'd1,
    PRESS    = 3'd2,
    RELEASE  = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  // True when at least one cell of a compact board (2 bits per cell) is empty.
  function automatic logic any_empty(input logic [17:0] board);
    logic r;
    r = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (board[2*c +: 2] == CELL_EMPTY) r = 1'b1;
    end
    return r;
  endfunction

  // Index of the sel-th (0-based, ascending) set bit of m; 0 if there is none.
  function automatic logic [3:0] pick_nth(input logic [8:0] m, input int unsigned sel);
    int unsigned k;
    logic [3:0] r;
    k = 0;
    r = 4'd0;
    for (int c = 0; c < 9; c++) begin
      if (m[c]) begin
        if (k == sel) r = 4'(c);
        k++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ttt_move_picker.sv
// Combinational move choice for player 2 on a compact board (2 bits per cell).
// Priority: win, block, centre, corners, edges. Ties go to the lowest index
// unless TTT_AUTO_LFSR_EN is defined, in which case corner/edge ties are
// broken by lfsr[1:0] modulo the number of candidates.
module ttt_move_picker
  import ttt_pkg::*;
(
  input  logic [17:0] board,
`ifdef TTT_AUTO_LFSR_EN
  input  logic [7:0]  lfsr,
`endif
  output logic [3:0]  idx,
  output logic        none
);

  logic [8:0] empty;
  logic [8:0] p1;
  logic [8:0] p2;
  logic [8:0] win;
  logic [8:0] blk;
  logic [8:0] corner_c;
  logic [8:0] edge_c;
  int unsigned corner_sel;
  int unsigned edge_sel;

  // Split the board into per-player occupancy masks; 2'b11 is occupied but owned by nobody.
  always_comb begin
    empty = '0;
    p1    = '0;
    p2    = '0;
    for (int c = 0; c < 9; c++) begin
      empty[c] = (board[2*c +: 2] == CELL_EMPTY);
      p1[c]    = (board[2*c +: 2] == CELL_P1);
      p2[c]    = (board[2*c +: 2] == CELL_P2);
    end
  end

  // Mark empty cells that would complete a P2 line (win) or a P1 line (block).
  always_comb begin
    win = '0;
    blk = '0;
    for (int l = 0; l < 8; l++) begin
      for (int k = 0; k < 3; k++) begin
        if (empty[LINES[l][k]] && p2[LINES[l][(k+1)%3]] && p2[LINES[l][(k+2)%3]])
          win[LINES[l][k]] = 1'b1;
        if (empty[LINES[l][k]] && p1[LINES[l][(k+1)%3]] && p1[LINES[l][(k+2)%3]])
          blk[LINES[l][k]] = 1'b1;
      end
    end
  end

  assign corner_c = empty & CORNER_MASK;
  assign edge_c   = empty & EDGE_MASK;

`ifdef TTT_AUTO_LFSR_EN
  // Random position within the corner/edge tiers.
  always_comb begin
    corner_sel = 0;
    edge_sel   = 0;
    if ($countones(corner_c) != 0)
      corner_sel = int'(lfsr[1:0]) % $countones(corner_c);
    if ($countones(edge_c) != 0)
      edge_sel = int'(lfsr[1:0]) % $countones(edge_c);
  end
`else
  assign corner_sel = 0;
  assign edge_sel   = 0;
`endif

  // Walk the tiers in priority order; the first non-empty tier supplies the move.
  always_comb begin
    idx  = 4'd0;
    none = 1'b0;
    if (|win)                 idx = pick_nth(win, 0);
    else if (|blk)            idx = pick_nth(blk, 0);
    else if (empty[CENTRE])   idx = 4'(CENTRE);
    else if (|corner_c)       idx = pick_nth(corner_c, corner_sel);
    else if (|edge_c)         idx = pick_nth(edge_c, edge_sel);
    else                      none = 1'b1;
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Automated player-2 opponent for the tic_tac_toe core. Waits for p2_turn,
// snapshots the board, thinks, presses one button for a fixed hold time,
// releases for a fixed gap and then waits for the core to hand the turn back.
// Optional feature macro: TTT_AUTO_LFSR_EN (random corner/edge tie-break).
// Handshake: a move is committed by move_valid (one cycle, first press cycle);
// the core acknowledges by dropping p2_turn, which must happen within
// TIMEOUT_CYCLES of the gap ending or the engine stalls until reset.
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter int THINK_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        auto_en,
  input  logic        p1_turn,
  input  logic        p2_turn,
  input  logic        p1_win,
  input  logic        p2_win,
  input  logic        grid_full,
  input  logic [26:0] board_led,
  output logic [8:0]  btn,
  output logic        busy,
  output logic        move_valid,
  output logic [3:0]  move_idx,
  output logic        stall,
  output logic [2:0]  state_dbg
);

  localparam int MAX_A = (THINK_CYCLES > HOLD_CYCLES) ? THINK_CYCLES : HOLD_CYCLES;
  localparam int MAX_B = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] THINK_LAST = CNT_W'(THINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [17:0]        board_live;
  logic [17:0]        cap, cap_n;
  logic [3:0]         idx_n;
  logic [8:0]         btn_n;
  logic               mv_n;
  logic               stall_n;
  logic [3:0]         pick_idx;
  logic               pick_none;
  logic               start;
  logic [8:0]         unused_led_bit2;
  logic               unused_inputs;

  // Drop the ignored LED bit 2 of each cell to get a 2-bit-per-cell board.
  always_comb begin
    board_live      = '0;
    unused_led_bit2 = '0;
    for (int c = 0; c < 9; c++) begin
      board_live[2*c +: 2] = board_led[3*c +: 2];
      unused_led_bit2[c]   = board_led[3*c + 2];
    end
  end

  // p1_turn is part of the core's flag bundle but does not steer the engine.
  assign unused_inputs = ^{p1_turn, unused_led_bit2};

`ifdef TTT_AUTO_LFSR_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  ttt_move_picker u_picker (
    .board (cap),
    .lfsr  (lfsr),
    .idx   (pick_idx),
    .none  (pick_none)
  );
`else
  ttt_move_picker u_picker (
    .board (cap),
    .idx   (pick_idx),
    .none  (pick_none)
  );
`endif

  // A stalled engine never starts another turn; only reset revives it.
  assign start = auto_en && p2_turn && !p1_win && !p2_win && !grid_full &&
                 !stall && any_empty(board_live);

  // Next-state and registered-output logic for the press sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    idx_n   = move_idx;
    btn_n   = '0;
    mv_n    = 1'b0;
    stall_n = stall;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = THINK;
          cap_n   = board_live;
        end
      end
      THINK: begin
        if (!auto_en || p1_win || p2_win || grid_full) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == THINK_LAST) begin
          cnt_n = '0;
          if (pick_none) begin
            state_n = IDLE;
          end else begin
            state_n = PRESS;
            idx_n   = pick_idx;
            btn_n   = 9'd1 << pick_idx;
            mv_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESS: begin
        if (cnt == HOLD_LAST) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          btn_n = btn;
        end
      end
      RELEASE: begin
        if (cnt == GAP_LAST) begin
          state_n = WAIT_ACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (!p2_turn) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          stall_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter, snapshot and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cap        <= '0;
      move_idx   <= '0;
      btn        <= '0;
      move_valid <= 1'b0;
      stall      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cap        <= cap_n;
      move_idx   <= idx_n;
      btn        <= btn_n;
      move_valid <= mv_n;
      stall      <= stall_n;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ttt_auto_player.sv
// Bench for ttt_auto_player: directed scenarios plus random boards checked
// against a cell-by-cell reference of the move priority rules.
module tb_ttt_auto_player;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_THINK    = 3'd1;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;

  logic        clk;
  logic        reset_n;
  logic        auto_en;
  logic        p1_turn;
  logic        p2_turn;
  logic        p1_win;
  logic        p2_win;
  logic        grid_full;
  logic [26:0] board_led;
  logic [8:0]  btn;
  logic        busy;
  logic        move_valid;
  logic [3:0]  move_idx;
  logic        stall;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference board: 0 empty, 1 P1, 2 P2, 3 both bits (occupied, nobody's).
  int bc [9];
  int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int corner_order [4] = '{0, 2, 6, 8};
  int edge_order   [4] = '{1, 3, 5, 7};

  ttt_auto_player dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .auto_en    (auto_en),
    .p1_turn    (p1_turn),
    .p2_turn    (p2_turn),
    .p1_win     (p1_win),
    .p2_win     (p2_win),
    .grid_full  (grid_full),
    .board_led  (board_led),
    .btn        (btn),
    .busy       (busy),
    .move_valid (move_valid),
    .move_idx   (move_idx),
    .stall      (stall),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_pick();
    for (int who = 2; who >= 1; who--) begin
      for (int c = 0; c < 9; c++) begin
        if (bc[c] == 0) begin
          for (int l = 0; l < 8; l++) begin
            int hits;
            bit on;
            hits = 0;
            on = 0;
            for (int k = 0; k < 3; k++) begin
              if (ln[l][k] == c) on = 1;
              else if (bc[ln[l][k]] == who) hits++;
            end
            if (on && hits == 2) return c;
          end
        end
      end
    end
    if (bc[4] == 0) return 4;
    for (int j = 0; j < 4; j++) if (bc[corner_order[j]] == 0) return corner_order[j];
    for (int j = 0; j < 4; j++) if (bc[edge_order[j]] == 0) return edge_order[j];
    return -1;
  endfunction

  function automatic logic [26:0] led_of_board();
    logic [26:0] v;
    v = '0;
    for (int c = 0; c < 9; c++) begin
      v[3*c +: 2] = 2'(bc[c]);
      v[3*c + 2]  = 1'($urandom_range(0, 1));
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_board();
    for (int c = 0; c < 9; c++) bc[c] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p2_turn = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Called at a negedge: present the board and hand the turn to P2.
  task automatic drive_turn();
    board_led = led_of_board();
    p1_turn   = 1'b0;
    p2_turn   = 1'b1;
  endtask

  task automatic finish_turn();
    p2_turn = 1'b0;
    p1_turn = 1'b1;
    step();
  endtask

  // Measures one press: cycles to move_valid, pressed button, hold and gap lengths.
  task automatic watch_press(output int lat, output logic [8:0] b0, output logic [3:0] i0,
                             output int hold, output int gap, output bit mv_extra);
    lat = -1; b0 = '0; i0 = '0; hold = 0; gap = 0; mv_extra = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (move_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) return;
    b0 = btn;
    i0 = move_idx;
    hold = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn !== b0) break;
      hold++;
      if (move_valid !== 1'b0) mv_extra = 1;
    end
    for (int c = 0; c < 20; c++) begin
      if (state_dbg !== S_RELEASE || btn !== 9'd0) break;
      gap++;
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++;
    if (btn !== 9'd0 || busy !== 1'b0 || move_valid !== 1'b0 || move_idx !== 4'd0 ||
        stall !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_values: btn=%h busy=%b mv=%b idx=%0d stall=%b state=%0d, required all zero",
               btn, busy, move_valid, move_idx, stall, state_dbg);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || btn !== 9'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b btn=%h, required 0 and 000", busy, btn);
    end
  endtask

  task automatic test_disabled();
    int hits;
    hits = 0;
    clear_board();
    auto_en = 1'b0;
    drive_turn();
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn !== 9'd0 || busy !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL disabled_idle: %0d cycles with btn/busy active, required 0", hits);
    end
    finish_turn();
    auto_en = 1'b1;
  endtask

  task automatic test_move(input string name, input logic [8:0] exp_btn);
    int lat, hold, gap;
    logic [8:0] b0;
    logic [3:0] i0;
    bit mv_extra;
    drive_turn();
    watch_press(lat, b0, i0, hold, gap, mv_extra);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s latency: move_valid after %0d cycles, required 3", name, lat);
    end
    checks++;
    if (b0 !== exp_btn || i0 !== 4'($clog2(exp_btn))) begin
      errors++;
      $display("FAIL %s button: btn=%h idx=%0d, required btn=%h", name, b0, i0, exp_btn);
    end
    checks++;
    if (hold != 4 || mv_extra) begin
      errors++;
      $display("FAIL %s hold: held %0d cycles (extra move_valid=%0b), required 4 and 0", name, hold, mv_extra);
    end
    checks++;
    if (gap != 4 || state_dbg !== S_WAIT_ACK) begin
      errors++;
      $display("FAIL %s gap: gap=%0d state=%0d, required 4 and WAIT_ACK", name, gap, state_dbg);
    end
    finish_turn();
    checks++;
    if (state_dbg !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ack: state=%0d busy=%b, required IDLE and 0", name, state_dbg, busy);
    end
  endtask

  task automatic test_first_move();
    clear_board();
    test_move("empty_board", 9'h010);
  endtask

  task automatic test_block();
    clear_board();
    bc[0] = 1; bc[1] = 1; bc[4] = 2;
    test_move("block", 9'h004);
  endtask

  task automatic test_win();
    clear_board();
    bc[0] = 2; bc[4] = 2; bc[1] = 1; bc[2] = 1;
    test_move("win", 9'h100);
  endtask

  task automatic test_abort_think();
    int hits;
    hits = 0;
    clear_board();
    drive_turn();
    step();
    checks++;
    if (state_dbg !== S_THINK) begin
      errors++;
      $display("FAIL abort_enter: state=%0d, required THINK", state_dbg);
    end
    p1_win = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (btn !== 9'd0 || move_valid !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_think: %0d press cycles busy=%b, required 0 and 0", hits, busy);
    end
    p1_win = 1'b0;
    finish_turn();
  endtask

  task automatic test_random();
    int lat, hold, gap, exp;
    logic [8:0] b0;
    logic [3:0] i0;
    bit mv_extra;
    for (int n = 0; n < 30; n++) begin
      for (int c = 0; c < 9; c++) begin
        int r;
        r = $urandom_range(0, 9);
        bc[c] = (r <= 3) ? 0 : (r <= 6) ? 1 : (r <= 8) ? 2 : 3;
      end
      bc[$urandom_range(0, 8)] = 0;
      exp = model_pick();
      drive_turn();
      watch_press(lat, b0, i0, hold, gap, mv_extra);
      checks++;
      if (lat != 3 || i0 !== 4'(exp) || b0 !== (9'd1 << exp)) begin
        errors++;
        $display("FAIL random_move[%0d]: lat=%0d idx=%0d btn=%h, required lat=3 idx=%0d", n, lat, i0, b0, exp);
      end
      checks++;
      if (hold != 4 || gap != 4) begin
        errors++;
        $display("FAIL random_timing[%0d]: hold=%0d gap=%0d, required 4 and 4", n, hold, gap);
      end
      finish_turn();
    end
  endtask

  task automatic test_reset_mid_press();
    int hits;
    bit seen;
    hits = 0;
    seen = 0;
    clear_board();
    bc[0] = 1; bc[1] = 1; bc[4] = 2;
    drive_turn();
    for (int c = 0; c < 12; c++) begin
      step();
      if (move_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    step();
    checks++;
    if (!seen || btn !== 9'h004) begin
      errors++;
      $display("FAIL midpress_setup: seen=%0b btn=%h, required 1 and 004", seen, btn);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (btn !== 9'd0 || busy !== 1'b0 || move_valid !== 1'b0 || move_idx !== 4'd0 ||
        stall !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL midpress_reset: btn=%h busy=%b mv=%b idx=%0d stall=%b state=%0d, required all zero",
               btn, busy, move_valid, move_idx, stall, state_dbg);
    end
    p2_turn = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn !== 9'd0 || busy !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL midpress_after: %0d active cycles after reset, required 0", hits);
    end
  endtask

  task automatic test_stall();
    int lat, hold, gap, early, hits;
    logic [8:0] b0;
    logic [3:0] i0;
    bit mv_extra;
    early = 0;
    hits = 0;
    clear_board();
    bc[4] = 1;
    drive_turn();
    watch_press(lat, b0, i0, hold, gap, mv_extra);
    checks++;
    if (b0 !== 9'h001 || state_dbg !== S_WAIT_ACK) begin
      errors++;
      $display("FAIL stall_setup: btn=%h state=%0d, required 001 and WAIT_ACK", b0, state_dbg);
    end
    for (int c = 0; c < 63; c++) begin
      step();
      if (stall !== 1'b0 || state_dbg !== S_WAIT_ACK) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL stall_early: %0d cycles left WAIT_ACK before timeout, required 0", early);
    end
    step();
    checks++;
    if (stall !== 1'b1 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL stall_set: stall=%b state=%0d, required 1 and IDLE", stall, state_dbg);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn !== 9'd0 || busy !== 1'b0 || stall !== 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL stall_sticky: %0d cycles pressing or unstalled, required 0", hits);
    end
    do_reset();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: stall=%b after reset, required 0", stall);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n   = 1'b0;
    auto_en   = 1'b1;
    p1_turn   = 1'b0;
    p2_turn   = 1'b0;
    p1_win    = 1'b0;
    p2_win    = 1'b0;
    grid_full = 1'b0;
    board_led = '0;
    clear_board();
    @(negedge clk);
    test_reset();
    test_disabled();
    test_first_move();
    test_block();
    test_win();
    test_abort_think();
    test_random();
    test_reset_mid_press();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
